array_request_stage: RTL and testbench

ARRAY_REQUEST_STAGE -- requirements
Module: array_request_stage

---
 rtl/array_request_stage_if.sv | 30 +++
 rtl/array_request_stage.sv | 140 ++++++++++++++
 tb/tb_array_request_stage.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/array_request_stage_if.sv
// Request-side handshake bundle for array_request_stage.
// The requester drives valid/address/data; the stage returns ready.
interface array_request_stage_if #(
    parameter int DW = 32
);
    logic          rd0_val;
    logic [0:5]    rd0_adr;
    logic          rd0_rdy;
    logic          rd1_val;
    logic [0:5]    rd1_adr;
    logic          rd1_rdy;
    logic          wr0_val;
    logic [0:5]    wr0_adr;
    logic [0:DW-1] wr0_dat;
    logic          wr0_rdy;

    modport master (
        output rd0_val, rd0_adr,
        output rd1_val, rd1_adr,
        output wr0_val, wr0_adr, wr0_dat,
        input  rd0_rdy, rd1_rdy, wr0_rdy
    );

    modport slave (
        input  rd0_val, rd0_adr,
        input  rd1_val, rd1_adr,
        input  wr0_val, wr0_adr, wr0_dat,
        output rd0_rdy, rd1_rdy, wr0_rdy
    );
endinterface

// File: rtl/array_request_stage.sv
// Request stage for a 64-word array: optional zero fill, then registered
// issue of two reads and one write with read-after-write hold per port.
module array_request_stage #(
    parameter int INIT_EN = 1,
    parameter int DW      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    array_request_stage_if.slave req,
    output logic                 rd_enb_0,
    output logic                 rd_enb_1,
    output logic                 wr_enb_0,
    output logic [0:5]           rd_adr_0,
    output logic [0:5]           rd_adr_1,
    output logic [0:5]           wr_adr_0,
    output logic [0:DW-1]        wr_dat_0,
    output logic                 init_done
);
    typedef enum logic {INIT, RUN} state_e;

    state_e        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [1:0]    hold_q, hold_d;
    logic [1:0]    fresh_q, fresh_d;
    logic [0:5]    hadr_q [2];
    logic [0:5]    hadr_d [2];
    logic [1:0]    renb_q, renb_d;
    logic [0:5]    radr_q [2];
    logic [0:5]    radr_d [2];
    logic          wenb_q, wenb_d;
    logic [0:5]    wadr_q, wadr_d;
    logic [0:DW-1] wdat_q, wdat_d;

    logic          run;
    logic          wacc;
    logic [1:0]    rrdy;
    logic [1:0]    rval;
    logic [0:5]    radr_in [2];
    logic [1:0]    cand;
    logic [0:5]    cadr [2];

    // fresh_q keeps rdy low while a read drained from the hold is on the array
    assign run        = (state_q == RUN) && !reset;
    assign rrdy       = {2{run}} & ~hold_q & ~fresh_q;
    assign wacc       = req.wr0_val & run;
    assign rval       = {req.rd1_val, req.rd0_val};
    assign radr_in[0] = req.rd0_adr;
    assign radr_in[1] = req.rd1_adr;

    assign req.rd0_rdy = rrdy[0];
    assign req.rd1_rdy = rrdy[1];
    assign req.wr0_rdy = run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        hold_d  = hold_q;
        hadr_d  = hadr_q;
        fresh_d = '0;
        renb_d  = '0;
        radr_d  = radr_q;
        wenb_d  = 1'b0;
        wadr_d  = wadr_q;
        wdat_d  = wdat_q;
        cand    = '0;
        cadr    = radr_in;
        unique case (state_q)
            INIT: begin
                wenb_d = 1'b1;
                wadr_d = cnt_q;
                wdat_d = '0;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                wenb_d = wacc;
                if (wacc) begin
                    wadr_d = req.wr0_adr;
                    wdat_d = req.wr0_dat;
                end
                for (int n = 0; n < 2; n++) begin
                    cand[n] = hold_q[n] | (rval[n] & rrdy[n]);
                    cadr[n] = hold_q[n] ? hadr_q[n] : radr_in[n];
                    if (cand[n] && wacc && cadr[n] == req.wr0_adr) begin
                        hold_d[n] = 1'b1;
                        hadr_d[n] = cadr[n];
                    end else if (cand[n]) begin
                        renb_d[n]  = 1'b1;
                        radr_d[n]  = cadr[n];
                        hold_d[n]  = 1'b0;
                        fresh_d[n] = hold_q[n];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (INIT_EN != 0) ? INIT : RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hold_q  <= '0;
            fresh_q <= '0;
            hadr_q  <= '{default: '0};
            renb_q  <= '0;
            radr_q  <= '{default: '0};
            wenb_q  <= 1'b0;
            wadr_q  <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            fresh_q <= fresh_d;
            hadr_q  <= hadr_d;
            renb_q  <= renb_d;
            radr_q  <= radr_d;
            wenb_q  <= wenb_d;
            wadr_q  <= wadr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign rd_enb_0  = renb_q[0];
    assign rd_enb_1  = renb_q[1];
    assign rd_adr_0  = radr_q[0];
    assign rd_adr_1  = radr_q[1];
    assign wr_enb_0  = wenb_q;
    assign wr_adr_0  = wadr_q;
    assign wr_dat_0  = wdat_q;
    // without a fill there is nothing to wait for once reset drops
    assign init_done = done_q | ((INIT_EN == 0) & ~reset);
endmodule

// File: tb/tb_array_request_stage.sv
// Bench for array_request_stage: behavioural model plus directed vectors,
// one fill-enabled instance and one fill-disabled instance.
module tb_array_request_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    array_request_stage_if #(.DW(DW)) ifa ();
    array_request_stage_if #(.DW(DW)) ifb ();

    logic          a_rd_enb_0, a_rd_enb_1, a_wr_enb_0, a_init_done;
    logic [0:5]    a_rd_adr_0, a_rd_adr_1, a_wr_adr_0;
    logic [0:DW-1] a_wr_dat_0;
    logic          b_rd_enb_0, b_rd_enb_1, b_wr_enb_0, b_init_done;
    logic [0:5]    b_rd_adr_0, b_rd_adr_1, b_wr_adr_0;
    logic [0:DW-1] b_wr_dat_0;

    array_request_stage #(.INIT_EN(1), .DW(DW)) dut_a (
        .clk(clk), .reset(reset), .req(ifa.slave),
        .rd_enb_0(a_rd_enb_0), .rd_enb_1(a_rd_enb_1),
        .wr_enb_0(a_wr_enb_0), .rd_adr_0(a_rd_adr_0),
        .rd_adr_1(a_rd_adr_1), .wr_adr_0(a_wr_adr_0),
        .wr_dat_0(a_wr_dat_0), .init_done(a_init_done)
    );

    array_request_stage #(.INIT_EN(0), .DW(DW)) dut_b (
        .clk(clk), .reset(reset), .req(ifb.slave),
        .rd_enb_0(b_rd_enb_0), .rd_enb_1(b_rd_enb_1),
        .wr_enb_0(b_wr_enb_0), .rd_adr_0(b_rd_adr_0),
        .rd_adr_1(b_rd_adr_1), .wr_adr_0(b_wr_adr_0),
        .wr_dat_0(b_wr_dat_0), .init_done(b_init_done)
    );

    int total = 0;
    int bad = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: fill progress, per-port pending read, post-drain cooldown
    bit            m_init;
    int            m_fill;
    bit            m_done;
    int            m_pend [2];
    bit            m_cool [2];
    bit            e_rd_enb [2];
    int            e_rd_adr [2];
    bit            e_wr_enb;
    int            e_wr_adr;
    logic [DW-1:0] e_wr_dat;
    bit            rv [2];
    int            ra [2];

    function automatic bit m_rdy(input int n);
        return !reset && !m_init && m_pend[n] < 0 && !m_cool[n];
    endfunction

    always @(posedge clk) begin
        started = 1;
        rv[0] = ifa.rd0_val;
        rv[1] = ifa.rd1_val;
        ra[0] = int'(ifa.rd0_adr);
        ra[1] = int'(ifa.rd1_adr);
        if (reset) begin
            m_init = 1;
            m_fill = 0;
            m_done = 0;
            e_wr_enb = 0;
            e_wr_adr = 0;
            e_wr_dat = '0;
            for (int n = 0; n < 2; n++) begin
                m_pend[n] = -1;
                m_cool[n] = 0;
                e_rd_enb[n] = 0;
                e_rd_adr[n] = 0;
            end
        end else if (m_init) begin
            e_wr_enb = 1;
            e_wr_adr = m_fill;
            e_wr_dat = '0;
            e_rd_enb[0] = 0;
            e_rd_enb[1] = 0;
            if (m_fill == 63) begin
                m_init = 0;
                m_done = 1;
            end
            m_fill++;
        end else begin
            e_wr_enb = ifa.wr0_val;
            if (ifa.wr0_val) begin
                e_wr_adr = int'(ifa.wr0_adr);
                e_wr_dat = ifa.wr0_dat;
            end
            for (int n = 0; n < 2; n++) begin
                int want;
                bit held;
                held = (m_pend[n] >= 0);
                want = -1;
                if (held) want = m_pend[n];
                else if (rv[n] && !m_cool[n]) want = ra[n];
                m_cool[n] = 0;
                e_rd_enb[n] = 0;
                if (want >= 0 && ifa.wr0_val && want == int'(ifa.wr0_adr)) begin
                    m_pend[n] = want;
                end else if (want >= 0) begin
                    e_rd_enb[n] = 1;
                    e_rd_adr[n] = want;
                    m_pend[n] = -1;
                    m_cool[n] = held;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m.wr_enb", 64'(a_wr_enb_0), 64'(e_wr_enb));
            if (e_wr_enb) begin
                chk("m.wr_adr", 64'(a_wr_adr_0), 64'(e_wr_adr));
                chk("m.wr_dat", 64'(a_wr_dat_0), 64'(e_wr_dat));
            end
            chk("m.rd_enb_0", 64'(a_rd_enb_0), 64'(e_rd_enb[0]));
            chk("m.rd_enb_1", 64'(a_rd_enb_1), 64'(e_rd_enb[1]));
            if (e_rd_enb[0]) chk("m.rd_adr_0", 64'(a_rd_adr_0), 64'(e_rd_adr[0]));
            if (e_rd_enb[1]) chk("m.rd_adr_1", 64'(a_rd_adr_1), 64'(e_rd_adr[1]));
            chk("m.rd0_rdy", 64'(ifa.rd0_rdy), 64'(m_rdy(0)));
            chk("m.rd1_rdy", 64'(ifa.rd1_rdy), 64'(m_rdy(1)));
            chk("m.wr0_rdy", 64'(ifa.wr0_rdy), 64'(!reset && !m_init));
            chk("m.init_done", 64'(a_init_done), 64'(m_done));
        end
    end

    task automatic idle_a();
        ifa.rd0_val = 0; ifa.rd0_adr = '0;
        ifa.rd1_val = 0; ifa.rd1_adr = '0;
        ifa.wr0_val = 0; ifa.wr0_adr = '0; ifa.wr0_dat = '0;
    endtask

    task automatic idle_b();
        ifb.rd0_val = 0; ifb.rd0_adr = '0;
        ifb.rd1_val = 0; ifb.rd1_adr = '0;
        ifb.wr0_val = 0; ifb.wr0_adr = '0; ifb.wr0_dat = '0;
    endtask

    // Present one cycle of requests; returns at the negedge showing the result
    task automatic cyc(input bit r0v, input int r0a, input bit r1v,
                       input int r1a, input bit wv, input int wa,
                       input logic [DW-1:0] wd);
        #1;
        ifa.rd0_val = r0v; ifa.rd0_adr = 6'(r0a);
        ifa.rd1_val = r1v; ifa.rd1_adr = 6'(r1a);
        ifa.wr0_val = wv;  ifa.wr0_adr = 6'(wa); ifa.wr0_dat = wd;
        @(posedge clk);
        #1 idle_a();
        @(negedge clk);
    endtask

    task automatic fill(input bit first, input int stop_at);
        for (int i = 0; i <= stop_at; i++) begin
            @(posedge clk);
            if (first && i == 0) begin
                #1 idle_b();
            end
            @(negedge clk);
            chk("fill.enb", 64'(a_wr_enb_0), 64'd1);
            chk("fill.adr", 64'(a_wr_adr_0), 64'(i));
            chk("fill.dat", 64'(a_wr_dat_0), 64'd0);
            if (first && i == 0) begin
                chk("b.rd_enb_0", 64'(b_rd_enb_0), 64'd1);
                chk("b.rd_adr_0", 64'(b_rd_adr_0), 64'd17);
                chk("b.rd_enb_1", 64'(b_rd_enb_1), 64'd0);
                chk("b.wr_enb_0", 64'(b_wr_enb_0), 64'd1);
                chk("b.wr_adr_0", 64'(b_wr_adr_0), 64'd2);
                chk("b.wr_dat_0", 64'(b_wr_dat_0), 64'hCAFE0002);
            end
            if (i < 63) begin
                chk("fill.done", 64'(a_init_done), 64'd0);
                chk("fill.rdy", 64'(ifa.rd0_rdy), 64'd0);
            end else begin
                chk("end.done", 64'(a_init_done), 64'd1);
                chk("end.rd0_rdy", 64'(ifa.rd0_rdy), 64'd1);
                chk("end.rd1_rdy", 64'(ifa.rd1_rdy), 64'd1);
                chk("end.wr0_rdy", 64'(ifa.wr0_rdy), 64'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        idle_a();
        idle_b();
        repeat (3) @(negedge clk);
        chk("rst.wr_enb", 64'(a_wr_enb_0), 64'd0);
        chk("rst.done", 64'(a_init_done), 64'd0);
        chk("rst.rd0_rdy", 64'(ifa.rd0_rdy), 64'd0);
        chk("rst.wr0_rdy", 64'(ifa.wr0_rdy), 64'd0);
        chk("rst.b_done", 64'(b_init_done), 64'd0);
        chk("rst.b_rdy", 64'(ifb.rd0_rdy), 64'd0);
        #1 reset = 0;
        #1;
        chk("b.done", 64'(b_init_done), 64'd1);
        chk("b.rd0_rdy", 64'(ifb.rd0_rdy), 64'd1);
        chk("b.wr0_rdy", 64'(ifb.wr0_rdy), 64'd1);
        ifb.rd0_val = 1; ifb.rd0_adr = 6'd17;
        ifb.wr0_val = 1; ifb.wr0_adr = 6'd2; ifb.wr0_dat = 32'hCAFE0002;
        fill(1, 63);

        cyc(1, 5, 1, 9, 1, 12, 32'h12345678);
        chk("par.rd_enb_0", 64'(a_rd_enb_0), 64'd1);
        chk("par.rd_adr_0", 64'(a_rd_adr_0), 64'd5);
        chk("par.rd_enb_1", 64'(a_rd_enb_1), 64'd1);
        chk("par.rd_adr_1", 64'(a_rd_adr_1), 64'd9);
        chk("par.wr_adr", 64'(a_wr_adr_0), 64'd12);
        chk("par.wr_dat", 64'(a_wr_dat_0), 64'h12345678);
        chk("par.rd0_rdy", 64'(ifa.rd0_rdy), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, '0);
        chk("idle.rd_enb_0", 64'(a_rd_enb_0), 64'd0);
        chk("idle.wr_enb", 64'(a_wr_enb_0), 64'd0);

        cyc(1, 7, 0, 0, 1, 7, 32'h77);
        chk("cf1.wr_enb", 64'(a_wr_enb_0), 64'd1);
        chk("cf1.rd_enb_0", 64'(a_rd_enb_0), 64'd0);
        chk("cf1.rd0_rdy", 64'(ifa.rd0_rdy), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, '0);
        chk("cf2.rd_enb_0", 64'(a_rd_enb_0), 64'd1);
        chk("cf2.rd_adr_0", 64'(a_rd_adr_0), 64'd7);
        chk("cf2.rd0_rdy", 64'(ifa.rd0_rdy), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, '0);
        chk("cf3.rd0_rdy", 64'(ifa.rd0_rdy), 64'd1);
        chk("cf3.rd_enb_0", 64'(a_rd_enb_0), 64'd0);

        cyc(0, 0, 1, 3, 1, 3, 32'h31);
        chk("rp0.rd_enb_1", 64'(a_rd_enb_1), 64'd0);
        cyc(1, 4, 0, 0, 1, 3, 32'h32);
        chk("rp1.rd_enb_1", 64'(a_rd_enb_1), 64'd0);
        chk("rp1.rd_enb_0", 64'(a_rd_enb_0), 64'd1);
        chk("rp1.rd_adr_0", 64'(a_rd_adr_0), 64'd4);
        chk("rp1.rd1_rdy", 64'(ifa.rd1_rdy), 64'd0);
        cyc(0, 0, 0, 0, 1, 3, 32'h33);
        chk("rp2.rd_enb_1", 64'(a_rd_enb_1), 64'd0);
        cyc(0, 0, 0, 0, 1, 3, 32'h34);
        chk("rp3.rd_enb_1", 64'(a_rd_enb_1), 64'd0);
        cyc(0, 0, 0, 0, 1, 8, 32'h35);
        chk("rp4.rd_enb_1", 64'(a_rd_enb_1), 64'd1);
        chk("rp4.rd_adr_1", 64'(a_rd_adr_1), 64'd3);
        chk("rp4.wr_adr", 64'(a_wr_adr_0), 64'd8);
        cyc(0, 0, 0, 0, 0, 0, '0);
        chk("rp5.rd1_rdy", 64'(ifa.rd1_rdy), 64'd1);

        cyc(1, 20, 1, 20, 1, 21, 32'h21);
        chk("same.rd_enb_0", 64'(a_rd_enb_0), 64'd1);
        chk("same.rd_enb_1", 64'(a_rd_enb_1), 64'd1);
        chk("same.rd_adr_1", 64'(a_rd_adr_1), 64'd20);
        cyc(1, 40, 1, 40, 1, 40, 32'h40);
        chk("both.rd_enb_0", 64'(a_rd_enb_0), 64'd0);
        chk("both.rd_enb_1", 64'(a_rd_enb_1), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, '0);
        chk("both2.rd_enb_0", 64'(a_rd_enb_0), 64'd1);
        chk("both2.rd_adr_1", 64'(a_rd_adr_1), 64'd40);

        for (int k = 0; k < 8; k++) begin
            cyc(k % 2 == 0, (k * 9) % 64, k % 3 != 0, (k * 13) % 64,
                1, (k * 13) % 64, 32'hF0000000 + 32'(k));
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, '0);

        cyc(1, 50, 0, 0, 1, 50, 32'h50);
        #1 reset = 1;
        @(negedge clk);
        chk("rh.wr_enb", 64'(a_wr_enb_0), 64'd0);
        chk("rh.rd_enb_0", 64'(a_rd_enb_0), 64'd0);
        chk("rh.rd0_rdy", 64'(ifa.rd0_rdy), 64'd0);
        chk("rh.done", 64'(a_init_done), 64'd0);
        #1 reset = 0;
        fill(0, 30);
        #1 reset = 1;
        @(negedge clk);
        chk("ri.wr_enb", 64'(a_wr_enb_0), 64'd0);
        chk("ri.wr_adr", 64'(a_wr_adr_0), 64'd0);
        chk("ri.done", 64'(a_init_done), 64'd0);
        #1 reset = 0;
        fill(0, 63);
        cyc(0, 0, 0, 0, 0, 0, '0);
        chk("drop.rd_enb_0", 64'(a_rd_enb_0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
